// File: rtl/conv_pkg.sv
// conv_pkg: geometry, word widths and FSM encoding shared by the convolution engine,
// its feeder and the OFM collector.
package conv_pkg;
    localparam int IFM_W = 14;
    localparam int K     = 3;
    localparam int DW    = 36;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int OFM_W = IFM_W - K + 1;
    localparam int OFM_N = OFM_W * OFM_W;
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/ofm_collector_if.sv
// ofm_collector_if: OFM beat stream from the engine plus the host read port.
interface ofm_collector_if;
    import conv_pkg::*;
    logic          in_valid;
    logic [DW-1:0] In_OFM;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    modport master (output in_valid, In_OFM, rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input in_valid, In_OFM, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/ofm_ram.sv
// ofm_ram: OFM_N x DW map storage, one write port and one registered read port.
module ofm_ram
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [OFM_N];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // Out-of-range or refused reads return zero rather than stale data.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else rdata <= (re && raddr < AW'(OFM_N)) ? mem[raddr] : '0;
endmodule

// File: rtl/ofm_collector.sv
// ofm_collector: drops row wrap-around beats, stores the 12x12 OFM in raster order,
// tracks the maximum word and serves the map through a 1-cycle read port.
module ofm_collector
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    ofm_collector_if.slave     s,
    output logic               out_done,
    output logic [DW-1:0]      Out_Max,
    output logic [AW-1:0]      Out_Max_Idx,
    output logic               overflow
);
    state_t        state, state_d;
    logic [CW-1:0] col, row;
    logic [AW-1:0] kept, n;
    logic          beat, keep, rd_ok, row_end;
    assign beat     = s.in_valid && !clear && state != DONE;
    assign keep     = beat && col < CW'(OFM_W);
    assign row_end  = col == CW'(IFM_W - 1);
    assign n        = AW'(row) * AW'(OFM_W) + AW'(col);
    assign rd_ok    = s.rd_en && state == DONE;
    assign out_done = state == DONE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        state_d = clear ? IDLE :
                  (state == IDLE && beat) ? CAPTURE :
                  (keep && kept == AW'(OFM_N - 1)) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            kept        <= '0;
            Out_Max     <= '0;
            Out_Max_Idx <= '0;
            overflow    <= 1'b0;
            s.rd_valid  <= 1'b0;
        end else begin
            s.rd_valid <= rd_ok;
            if (clear) begin
                col         <= '0;
                row         <= '0;
                kept        <= '0;
                Out_Max     <= '0;
                Out_Max_Idx <= '0;
                overflow    <= 1'b0;
            end else begin
                if (beat) begin
                    col <= row_end ? '0 : col + 1'b1;
                    row <= row_end ? row + 1'b1 : row;
                end
                if (keep) kept <= kept + 1'b1;
                // First kept word seeds the max so a stale value never survives a new map.
                if (keep && (n == '0 || s.In_OFM > Out_Max)) begin
                    Out_Max     <= s.In_OFM;
                    Out_Max_Idx <= n;
                end
                if (state == DONE && s.in_valid) overflow <= 1'b1;
            end
        end
    ofm_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (keep),
        .waddr (n),
        .wdata (s.In_OFM),
        .re    (rd_ok),
        .raddr (s.rd_addr),
        .rdata (s.rd_data)
    );
endmodule

// File: tb/tb_ofm_collector.sv
// tb_ofm_collector: directed checks of capture, gaps, max tracking, reads and aborts.
module tb_ofm_collector;
    import conv_pkg::*;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          out_done, overflow;
    logic [DW-1:0] Out_Max;
    logic [AW-1:0] Out_Max_Idx;
    logic [DW-1:0] exp_mem [OFM_N];
    int            n_chk = 0;
    int            n_fail = 0;
    ofm_collector_if bus ();
    ofm_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .s           (bus),
        .out_done    (out_done),
        .Out_Max     (Out_Max),
        .Out_Max_Idx (Out_Max_Idx),
        .overflow    (overflow)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [DW-1:0] val(input int mode, input int i);
        int c = i % IFM_W;
        int k = (i / IFM_W) * OFM_W + c;
        case (mode)
            0: val = DW'(i);
            1: val = (c < OFM_W && (k == 5 || k == 90)) ? 36'hF_FFFF_FFFF : 36'h0_0000_0007;
            2: val = DW'(i + 1000);
            default: val = DW'(2 * i);
        endcase
    endfunction

    task automatic send(input logic [DW-1:0] v);
        bus.in_valid = 1'b1;
        bus.In_OFM   = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic stream(input int mode, input int first, input int last, input int ga, input int gb);
        for (int i = first; i <= last; i++) begin
            logic [DW-1:0] v = val(mode, i);
            if (i % IFM_W < OFM_W) exp_mem[(i / IFM_W) * OFM_W + i % IFM_W] = v;
            send(v);
            if (i == ga || i == gb) repeat (3) @(negedge clk);
        end
    endtask

    task automatic rd(input int a, input logic [DW-1:0] req, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(a);
        @(negedge clk);
        bus.rd_en   = 1'b0;
        chk({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        chk(tag, 64'(bus.rd_data), 64'(req));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.In_OFM   = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(out_done), 64'd0);
        chk("rst_max", 64'(Out_Max), 64'd0);
        chk("rst_idx", 64'(Out_Max_Idx), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // contiguous stream, value = beat index
        stream(0, 0, 164, -1, -1);
        chk("s1_done_early", 64'(out_done), 64'd0);
        stream(0, 165, 165, -1, -1);
        chk("s1_done", 64'(out_done), 64'd1);
        chk("s1_max", 64'(Out_Max), 64'd165);
        chk("s1_idx", 64'(Out_Max_Idx), 64'd143);
        rd(0, 36'd0, "s1_m0");
        rd(12, 36'd14, "s1_m12");
        rd(77, 36'd89, "s1_m77");
        rd(143, 36'd165, "s1_m143");
        // back-to-back reads in DONE, last one out of range
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'd0;
        @(negedge clk);
        chk("s4_v0", 64'(bus.rd_valid), 64'd1);
        chk("s4_d0", 64'(bus.rd_data), 64'(exp_mem[0]));
        bus.rd_addr = 8'd1;
        @(negedge clk);
        chk("s4_v1", 64'(bus.rd_valid), 64'd1);
        chk("s4_d1", 64'(bus.rd_data), 64'(exp_mem[1]));
        bus.rd_addr = 8'd143;
        @(negedge clk);
        chk("s4_v143", 64'(bus.rd_valid), 64'd1);
        chk("s4_d143", 64'(bus.rd_data), 64'(exp_mem[143]));
        bus.rd_addr = 8'd200;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("s4_v200", 64'(bus.rd_valid), 64'd1);
        chk("s4_d200", 64'(bus.rd_data), 64'd0);
        @(negedge clk);
        chk("s4_v_idle", 64'(bus.rd_valid), 64'd0);
        repeat (10) send(36'h9_8765_4321);
        chk("s4_done_kept", 64'(out_done), 64'd1);
        chk("s4_max_kept", 64'(Out_Max), 64'd165);
        chk("s4_overflow", 64'(overflow), 64'd1);
        rd(0, exp_mem[0], "s4_m0_kept");
        rd(143, exp_mem[143], "s4_m143_kept");
        // same stream with two 3-cycle gaps
        pulse_clear();
        chk("clr_done", 64'(out_done), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_max", 64'(Out_Max), 64'd0);
        stream(0, 0, 164, 12, 99);
        chk("s2_done_early", 64'(out_done), 64'd0);
        stream(0, 165, 165, -1, -1);
        chk("s2_done", 64'(out_done), 64'd1);
        chk("s2_max", 64'(Out_Max), 64'd165);
        chk("s2_idx", 64'(Out_Max_Idx), 64'd143);
        rd(12, 36'd14, "s2_m12");
        rd(143, 36'd165, "s2_m143");
        // two equal maxima, first wins
        pulse_clear();
        stream(1, 0, 165, -1, -1);
        chk("s3_done", 64'(out_done), 64'd1);
        chk("s3_max", 64'(Out_Max), 64'hF_FFFF_FFFF);
        chk("s3_idx", 64'(Out_Max_Idx), 64'd5);
        rd(90, 36'hF_FFFF_FFFF, "s3_m90");
        rd(4, 36'd7, "s3_m4");
        // read refused while capturing
        pulse_clear();
        stream(0, 0, 29, -1, -1);
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'd0;
        @(negedge clk);
        chk("s5_v0", 64'(bus.rd_valid), 64'd0);
        chk("s5_d0", 64'(bus.rd_data), 64'd0);
        bus.rd_addr = 8'd5;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("s5_v5", 64'(bus.rd_valid), 64'd0);
        chk("s5_d5", 64'(bus.rd_data), 64'd0);
        // clear abort after 50 beats
        pulse_clear();
        stream(0, 0, 49, -1, -1);
        pulse_clear();
        chk("s6_clr_done", 64'(out_done), 64'd0);
        chk("s6_clr_max", 64'(Out_Max), 64'd0);
        stream(2, 0, 165, -1, -1);
        chk("s6a_done", 64'(out_done), 64'd1);
        chk("s6a_max", 64'(Out_Max), 64'd1165);
        chk("s6a_idx", 64'(Out_Max_Idx), 64'd143);
        rd(0, 36'd1000, "s6a_m0");
        rd(12, 36'd1014, "s6a_m12");
        // reset abort after 70 beats
        pulse_clear();
        stream(0, 0, 69, -1, -1);
        rst_n = 1'b0;
        #2;
        chk("s6_rst_done", 64'(out_done), 64'd0);
        chk("s6_rst_max", 64'(Out_Max), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stream(3, 0, 165, -1, -1);
        chk("s6b_done", 64'(out_done), 64'd1);
        chk("s6b_max", 64'(Out_Max), 64'd330);
        chk("s6b_idx", 64'(Out_Max_Idx), 64'd143);
        rd(12, 36'd28, "s6b_m12");
        rd(143, 36'd330, "s6b_m143");
        // clear coincident with a beat drops the beat
        pulse_clear();
        stream(0, 0, 19, -1, -1);
        clear = 1'b1;
        send(36'hA_BCDE_F012);
        clear = 1'b0;
        chk("s6c_max", 64'(Out_Max), 64'd0);
        chk("s6c_idx", 64'(Out_Max_Idx), 64'd0);
        stream(0, 0, 164, -1, -1);
        chk("s6c_done_early", 64'(out_done), 64'd0);
        stream(0, 165, 165, -1, -1);
        chk("s6c_done", 64'(out_done), 64'd1);
        chk("s6c_max_end", 64'(Out_Max), 64'd165);
        rd(20, 36'd22, "s6c_m20");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
